// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared op codes, descriptor layout, error codes and FSM states for the DMA host interface
package dma_pkg;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b10;

    localparam int CNT_W   = 6;
    localparam int ADDR_W  = 13;
    localparam int DST_LSB = 0;
    localparam int SRC_LSB = ADDR_W;
    localparam int CNT_LSB = 2 * ADDR_W;
    localparam int DESC_W  = CNT_W + 2 * ADDR_W;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {IDLE, REQ, GRANT, XFER, FIN} state_t;

    function automatic logic [DESC_W-1:0] pack_desc(input logic [CNT_W-1:0] cnt,
                                                    input logic [ADDR_W-1:0] s,
                                                    input logic [ADDR_W-1:0] d);
        return (DESC_W'(cnt) << CNT_LSB) | (DESC_W'(s) << SRC_LSB) | (DESC_W'(d) << DST_LSB);
    endfunction

    function automatic logic op_legal(input logic [1:0] o);
        return (o == OP_READ) || (o == OP_MOVE);
    endfunction

endpackage

// File: rtl/dma_watchdog.sv
// rtl/dma_watchdog.sv - 8-bit wait-state watchdog with clear, enable and expire
module dma_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;
    logic [7:0] eff;

    // clr marks the first cycle of a state, so that cycle counts from zero
    assign eff    = clr ? 8'd0 : cnt;
    assign expire = en && (eff == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= eff + 8'd1;
        end else if (clr) begin
            cnt <= 8'd0;
        end
    end

endmodule

// File: rtl/dma_host_if.sv
// rtl/dma_host_if.sv - host-side DMA request/grant handshake FSM with descriptor drive and result capture
module dma_host_if
    import dma_pkg::*;
#(
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [DW-1:0]     rdata,
    output logic              dreq,
    input  logic              hreq,
    output logic              hack,
    input  logic              dack,
    output logic [1:0]        cmd,
    output logic              cmd_oe,
    input  logic              dma_int,
    input  logic [DW-1:0]     bus_in,
    output logic [DW-1:0]     bus_out,
    output logic              bus_oe
);

    state_t            state;
    logic [1:0]        op_q;
    logic [DESC_W-1:0] desc_q;
    logic              entry;
    logic              wd_en;
    logic              wd_expire;

    assign wd_en = (state == REQ) || (state == GRANT) || (state == XFER);

    dma_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (entry),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= OP_READ;
            desc_q  <= '0;
            entry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= ERR_OK;
            rdata   <= '0;
            dreq    <= 1'b0;
            hack    <= 1'b0;
            cmd     <= 2'b00;
            cmd_oe  <= 1'b0;
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end else begin
            done  <= 1'b0;
            entry <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        desc_q <= pack_desc(count, src, dst);
                        busy   <= 1'b1;
                        entry  <= 1'b1;
                        if (!op_legal(op)) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= ERR_ILLEGAL;
                        end else if (count == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= ERR_OK;
                        end else begin
                            state <= REQ;
                            dreq  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (hreq) begin
                        state   <= GRANT;
                        entry   <= 1'b1;
                        hack    <= 1'b1;
                        bus_oe  <= 1'b1;
                        bus_out <= DW'(desc_q);
                    end else if (wd_expire) begin
                        state <= FIN;
                        entry <= 1'b1;
                        done  <= 1'b1;
                        err   <= ERR_TIMEOUT;
                        dreq  <= 1'b0;
                    end
                end
                GRANT: begin
                    // int is deliberately not looked at until XFER
                    if (dack) begin
                        state   <= XFER;
                        entry   <= 1'b1;
                        bus_oe  <= 1'b0;
                        bus_out <= '0;
                        cmd     <= op_q;
                        cmd_oe  <= 1'b1;
                    end else if (wd_expire) begin
                        state   <= FIN;
                        entry   <= 1'b1;
                        done    <= 1'b1;
                        err     <= ERR_TIMEOUT;
                        dreq    <= 1'b0;
                        hack    <= 1'b0;
                        bus_oe  <= 1'b0;
                        bus_out <= '0;
                    end
                end
                XFER: begin
                    if (dma_int || wd_expire) begin
                        state  <= FIN;
                        entry  <= 1'b1;
                        done   <= 1'b1;
                        err    <= dma_int ? ERR_OK : ERR_TIMEOUT;
                        dreq   <= 1'b0;
                        hack   <= 1'b0;
                        cmd    <= 2'b00;
                        cmd_oe <= 1'b0;
                        if (dma_int) begin
                            rdata <= bus_in;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    entry <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_host_if.sv
// tb/tb_dma_host_if.sv - randomized self-checking bench for dma_host_if against a phase-timeline model
module tb_dma_host_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  count;
    logic [12:0] src;
    logic [12:0] dst;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        dreq;
    logic        hreq;
    logic        hack;
    logic        dack;
    logic [1:0]  cmd;
    logic        cmd_oe;
    logic        dma_int;
    logic [31:0] bus_in;
    logic [31:0] bus_out;
    logic        bus_oe;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rdata_exp;

    always #5 clk = ~clk;

    dma_host_if #(.DW(32), .TIMEOUT_CYC(255)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .count   (count),
        .src     (src),
        .dst     (dst),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .dreq    (dreq),
        .hreq    (hreq),
        .hack    (hack),
        .dack    (dack),
        .cmd     (cmd),
        .cmd_oe  (cmd_oe),
        .dma_int (dma_int),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .bus_oe  (bus_oe)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // a/b/c: cycles spent in REQ/GRANT/XFER before the DMA responds; <=0 means it never does
    task automatic run_case(input logic [1:0] o, input logic [5:0] n, input logic [12:0] s,
                            input logic [12:0] d, input int a, input int b, input int c,
                            input int rst_at, input bit fix_bus, input logic [31:0] bus_val);
        int          la, lb, lc, fin_k, p;
        bit          ta, tbo, tc;
        logic [31:0] desc_exp;
        logic [1:0]  err_exp;
        logic [5:0]  ctrl_exp;
        desc_exp = 32'(n) * 32'h0400_0000 + 32'(s) * 32'h0000_2000 + 32'(d);
        ta  = (a <= 0);
        tbo = (b <= 0);
        tc  = (c <= 0);
        la  = ta  ? 255 : a;
        lb  = tbo ? 255 : b;
        lc  = tc  ? 255 : c;
        err_exp = 2'b00;
        if (!(o == 2'b00 || o == 2'b10)) begin
            fin_k = 1; err_exp = 2'b10;
        end else if (n == 6'd0) begin
            fin_k = 1;
        end else if (ta) begin
            fin_k = la + 1; err_exp = 2'b01;
        end else if (tbo) begin
            fin_k = la + lb + 1; err_exp = 2'b01;
        end else begin
            fin_k = la + lb + lc + 1; err_exp = tc ? 2'b01 : 2'b00;
        end

        @(negedge clk);
        start = 1'b1; op = o; count = n; src = s; dst = d;
        hreq = 1'b0; dack = 1'b0; dma_int = 1'b0;
        for (int k = 1; k <= fin_k + 1; k++) begin
            @(negedge clk);
            if (k == fin_k)     p = 4;
            else if (k > fin_k) p = 0;
            else if (k <= la)   p = 1;
            else if (k <= la + lb) p = 2;
            else                p = 3;
            ctrl_exp = {p != 0, p inside {1, 2, 3}, p inside {2, 3}, p == 2, p == 3, p == 4};
            chk("ctrl{busy,dreq,hack,bus_oe,cmd_oe,done}", {busy, dreq, hack, bus_oe, cmd_oe, done}, ctrl_exp);
            if (p == 2) chk("bus_out_desc", bus_out, desc_exp);
            if (p == 3) chk("cmd", cmd, o);
            if (p == 4) begin
                chk("err", err, err_exp);
                chk("rdata_done", rdata, rdata_exp);
            end
            if (p == 0) chk("rdata_idle", rdata, rdata_exp);

            if (k == rst_at) begin
                #2 reset = 1'b0;
                #1 chk("rst_async_ctrl", {busy, dreq, hack, bus_oe, cmd_oe, done}, 6'd0);
                rdata_exp = 32'd0;
                chk("rst_async_rdata", rdata, rdata_exp);
                start = 1'b0; hreq = 1'b0; dack = 1'b0; dma_int = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                break;
            end

            start = (p != 0) ? 1'($urandom) : 1'b0;
            op    = 2'($urandom);
            count = 6'($urandom);
            src   = 13'($urandom);
            dst   = 13'($urandom);
            hreq    = (p == 1) ? (k == la && !ta) : (p == 2 || p == 3) ? 1'($urandom) : 1'b0;
            dack    = (p == 2) ? (k == la + lb && !tbo) : (p == 3) ? 1'($urandom) : 1'b0;
            dma_int = (p == 1 || p == 2) ? 1'($urandom) : (p == 3) ? (k == la + lb + lc && !tc) : 1'b0;
            bus_in  = fix_bus ? bus_val : $urandom;
            if (p == 3 && dma_int) rdata_exp = bus_in;
        end
    endtask

    initial begin
        logic [1:0] ro;
        reset = 1'b0; start = 1'b0; op = 2'b00; count = 6'd0; src = 13'd0; dst = 13'd0;
        hreq = 1'b0; dack = 1'b0; dma_int = 1'b0; bus_in = 32'd0;
        rdata_exp = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, dreq, hack, bus_oe, cmd_oe, done}, 6'd0);
        chk("reset_err", err, 2'b00);
        chk("reset_cmd", cmd, 2'b00);
        chk("reset_bus_out", bus_out, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        reset = 1'b1;

        run_case(2'b00, 6'd1, 13'd5, 13'd0, 2, 1, 3, 0, 1'b1, 32'h5);
        chk("read_rdata", rdata, 32'h5);
        run_case(2'b10, 6'd2, 13'd5, 13'd8, 3, 2, 2, 0, 1'b0, 32'd0);
        run_case(2'b10, 6'd0, 13'd7, 13'd9, 1, 1, 1, 0, 1'b0, 32'd0);
        run_case(2'b01, 6'd5, 13'd1, 13'd2, 1, 1, 1, 0, 1'b0, 32'd0);
        run_case(2'b11, 6'd0, 13'd1, 13'd2, 1, 1, 1, 0, 1'b0, 32'd0);
        run_case(2'b00, 6'd3, 13'd4, 13'd6, 0, 1, 1, 0, 1'b0, 32'd0);
        run_case(2'b10, 6'd3, 13'd4, 13'd6, 2, 0, 1, 0, 1'b0, 32'd0);
        run_case(2'b00, 6'd3, 13'd4, 13'd6, 1, 1, 0, 0, 1'b0, 32'd0);
        run_case(2'b10, 6'd4, 13'h1fff, 13'h1fff, 2, 2, 5, 6, 1'b0, 32'd0);
        run_case(2'b00, 6'h3f, 13'h1abc, 13'h0123, 1, 1, 1, 0, 1'b0, 32'd0);

        for (int i = 0; i < 25; i++) begin
            ro = ($urandom_range(0, 5) == 0) ? 2'($urandom) : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
            run_case(ro, ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom),
                     13'($urandom), 13'($urandom),
                     $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8),
                     0, 1'b0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_host_if.md
Name: dma_host_if

Overview:
- Processor-side (host) end of the DMA request/grant handshake.
- Accepts a transfer descriptor from the core, raises dreq and grants the bus on hreq with hack. It then drives the packed instruction word onto the shared data bus, releases the bus on dack and issues cmd. It waits for the DMA int, captures the returned data word and reports done.
- Sits between the core register file and the shared bus, memory, io and DMA fabric. It replaces the ad hoc mode-driven handshake logic in the core.

Parameters:
- DW, 32, data bus width.
- TIMEOUT_CYC, 255, maximum cycles spent in any wait state before abort; 8-bit counter.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  core request strobe, sampled only in IDLE.
- op  in  2  2'b00 read, 2'b10 move; other values illegal.
- count  in  6  transfer word count.
- src  in  13  source address.
- dst  in  13  destination address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  valid with done: 00 ok, 01 timeout, 10 illegal op.
- rdata  out  DW  word captured from bus at int.
- dreq  out  1  DMA request.
- hreq  in  1  DMA wants bus.
- hack  out  1  bus granted to DMA.
- dack  in  1  DMA has taken bus.
- cmd  out  2  DMA command, valid when cmd_oe=1.
- cmd_oe  out  1  cmd drive enable.
- int  in  1  DMA finished.
- bus_in  in  DW  data bus sampled value.
- bus_out  out  DW  data bus drive value.
- bus_oe  out  1  data bus drive enable; top level tristates the bus when 0.

Behaviour:
- Reset (async, active-low): state=IDLE; dreq, hack, cmd_oe, bus_oe, done, busy=0; err=00; cmd=00; bus_out=0; rdata=0; watchdog=0. Reset asserted mid-transfer drops all drives immediately.
- Descriptor packing: desc = {count[5:0], src[12:0], dst[12:0]}, i.e. count in bits 31:26, src in 25:13, dst in 12:0. Latched together with op on the start edge.
- IDLE, start=1, op legal, count≠0: go to REQ.
- IDLE, start=1, count=0: go to FIN with err=00. No handshake; rdata unchanged.
- IDLE, start=1, op illegal: go to FIN with err=10. No handshake.
- start outside IDLE: ignored.
- REQ: dreq=1.
  - hreq=1 sampled: go to GRANT.
- GRANT: dreq=1, hack=1, bus_oe=1, bus_out=desc.
  - dack=1 sampled: go to XFER.
- XFER: dreq=1, hack=1, bus_oe=0, cmd=latched op, cmd_oe=1.
  - int=1 sampled: rdata<=bus_in on the same edge, then go to FIN with err=00.
- FIN: done=1 for exactly one cycle; dreq, hack, cmd_oe, bus_oe=0; then go to IDLE.
- Latency:
  - start edge → dreq high one cycle later.
  - hreq edge → hack and bus_oe high the next cycle.
  - dack edge → bus released and cmd_oe high the next cycle.
  - int edge → done the next cycle.
- Watchdog: clears on every state entry and counts in REQ, GRANT and XFER.
  - Reaching TIMEOUT_CYC: go to FIN with err=01; rdata unchanged.
- int sampled in REQ or GRANT: ignored.
- hreq falling in GRANT or XFER: ignored; grant held until FIN.
- dack falling in XFER: ignored.
- dack and int high in the same GRANT cycle: go to XFER only; int is evaluated from XFER onward.
- bus_oe and cmd_oe are never high in the same cycle.

Decomposition:
- Shared package dma_pkg holds:
  - op codes OP_READ=2'b00 and OP_MOVE=2'b10;
  - field widths CNT_W=6 and ADDR_W=13, with field bit positions;
  - err codes;
  - state enum {IDLE, REQ, GRANT, XFER, FIN}.
- One sub-module, dma_watchdog: 8-bit counter with clear, enable and expire output. All other logic stays in the dma_host_if FSM.

Test Plan:
- Read, op=00, count=1, src=5, dst=0; DMA model asserts hreq 2 cycles after dreq, dack 1 cycle after hack, and int after 3 cycles with bus_in=0x5.
  - Required: bus_out=0x0400A000 while bus_oe; cmd=00; rdata=0x5; done with err=00; total 1+2+1+1+3+1 cycle ordering checked.
- Move, op=10, count=2, src=5, dst=8.
  - Required: desc=0x0800A008; cmd=10 and cmd_oe=1 only after dack; bus_oe=0 throughout XFER.
- Start with count=0.
  - Required: done one cycle after start; dreq never rises; err=00.
- Start with op=01.
  - Required: done with err=10; no dreq.
- hreq held low for 300 cycles.
  - Required: abort at 255 cycles in REQ; done with err=01; dreq drops in FIN.
- reset pulsed low in XFER.
  - Required: hack, dreq and cmd_oe low asynchronously; next start completes normally.
